// File: rtl/conv_out_packer_if.sv
// Signal bundle between the convolutional encoder, the output packer and its three byte FIFOs.
// master = encoder/FIFO side driving the packer, slave = the packer itself.
interface conv_out_packer_if;
  logic        blk_start;
  logic [7:0]  blk_meta;
  logic        enc_valid;
  logic [2:0]  dIn;
  logic [2:0]  fifo_full;
  logic [7:0]  out_d0;
  logic [7:0]  out_d1;
  logic [7:0]  out_d2;
  logic        wrreq_out;
  logic        blk_done;
  logic        busy;
  logic        len_err;
  logic        overflow;
  logic [12:0] bit_cnt;

  modport master (
    output blk_start, blk_meta, enc_valid, dIn, fifo_full,
    input  out_d0, out_d1, out_d2, wrreq_out, blk_done, busy, len_err, overflow, bit_cnt
  );

  modport slave (
    input  blk_start, blk_meta, enc_valid, dIn, fifo_full,
    output out_d0, out_d1, out_d2, wrreq_out, blk_done, busy, len_err, overflow, bit_cnt
  );
endinterface

// File: rtl/conv_out_packer.sv
// Packs the three coded streams of the tail-biting encoder MSB-first into bytes and
// writes them in lockstep to three FIFOs, tracking block length and error conditions.
module conv_out_packer #(
  parameter int LEN_SMALL = 1056,
  parameter int LEN_LARGE = 6144
) (
  input  logic               clk,
  input  logic               reset,
  conv_out_packer_if.slave   bus
);

  localparam logic [12:0] L_SMALL = 13'(LEN_SMALL);
  localparam logic [12:0] L_LARGE = 13'(LEN_LARGE);

  typedef enum logic [1:0] {IDLE, PACK, LAST} state_t;

  state_t      state, state_nx;
  logic [12:0] exp_len;
  logic [12:0] bit_cnt;
  logic [7:0]  sr0, sr1, sr2;
  logic [7:0]  out_d0, out_d1, out_d2;
  logic        wrreq_q, done_q, len_err_q, abort_q, overflow_q;

  logic load, abort, accept, err_set, last_bit;
  logic byte_done, do_write, drop;

  // Only bit 0 of the meta byte carries information.
  logic unused_meta;
  assign unused_meta = ^bus.blk_meta[7:1];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    abort    = 1'b0;
    accept   = 1'b0;
    err_set  = 1'b0;
    last_bit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.blk_start) begin
          load     = 1'b1;
          state_nx = PACK;
        end else if (bus.enc_valid) begin
          err_set = 1'b1;
        end
      end
      PACK: begin
        // A restart wins over any bit or byte completion arriving in the same cycle.
        if (bus.blk_start) begin
          load  = 1'b1;
          abort = 1'b1;
        end else if (bus.enc_valid) begin
          accept = 1'b1;
          if (bit_cnt == exp_len - 13'd1) begin
            last_bit = 1'b1;
            state_nx = LAST;
          end
        end
      end
      LAST: begin
        state_nx = IDLE;
        if (bus.enc_valid) err_set = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign byte_done = accept && (bit_cnt[2:0] == 3'd7);
  assign do_write  = byte_done && (bus.fifo_full == 3'b000);
  assign drop      = byte_done && (bus.fifo_full != 3'b000);

  // An abort raises abort_q for one cycle while the restart clears the sticky flag,
  // so len_err shows a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_len    <= '0;
      bit_cnt    <= '0;
      sr0        <= '0;
      sr1        <= '0;
      sr2        <= '0;
      out_d0     <= '0;
      out_d1     <= '0;
      out_d2     <= '0;
      wrreq_q    <= 1'b0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
      abort_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wrreq_q <= do_write;
      done_q  <= last_bit;
      abort_q <= abort;
      if (load) begin
        exp_len   <= bus.blk_meta[0] ? L_LARGE : L_SMALL;
        bit_cnt   <= '0;
        sr0       <= '0;
        sr1       <= '0;
        sr2       <= '0;
        len_err_q <= 1'b0;
      end else begin
        if (err_set) len_err_q <= 1'b1;
        if (accept) begin
          sr0     <= {sr0[6:0], bus.dIn[0]};
          sr1     <= {sr1[6:0], bus.dIn[1]};
          sr2     <= {sr2[6:0], bus.dIn[2]};
          bit_cnt <= bit_cnt + 13'd1;
        end
      end
      if (do_write) begin
        out_d0 <= {sr0[6:0], bus.dIn[0]};
        out_d1 <= {sr1[6:0], bus.dIn[1]};
        out_d2 <= {sr2[6:0], bus.dIn[2]};
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign bus.out_d0    = out_d0;
  assign bus.out_d1    = out_d1;
  assign bus.out_d2    = out_d2;
  assign bus.wrreq_out = wrreq_q;
  assign bus.blk_done  = done_q;
  assign bus.busy      = (state != IDLE);
  assign bus.len_err   = len_err_q | abort_q;
  assign bus.overflow  = overflow_q;
  assign bus.bit_cnt   = bit_cnt;

endmodule

// File: tb/tb_conv_out_packer.sv
// Directed bench for conv_out_packer: full blocks of both lengths, gaps, FIFO-full drop,
// restart abort, stray enc_valid and mid-block reset, with hand-computed expectations.
module tb_conv_out_packer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   n_writes, n_done, pat_err;

  conv_out_packer_if bus ();

  conv_out_packer #(.LEN_SMALL(1056), .LEN_LARGE(6144)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream patterns: 0 -> 101 constant, 1 -> d0 alternating from 1 with d1=1 d2=0,
  // 2 -> d0 = 11110000, d1 = 01010101, d2 = 10000000 per byte.
  function automatic logic [2:0] pattern(input int mode, input int g);
    case (mode)
      0:       return 3'b101;
      1:       return {1'b0, 1'b1, (g % 2 == 0)};
      default: return {(g % 8 == 0), (g % 2 == 1), (g % 8 < 4)};
    endcase
  endfunction

  function automatic logic [23:0] pattern_bytes(input int mode);
    case (mode)
      0:       return {8'hFF, 8'h00, 8'hFF};
      1:       return {8'h00, 8'hFF, 8'hAA};
      default: return {8'h80, 8'h55, 8'hF0};
    endcase
  endfunction

  task automatic applyStimulus(input logic [7:0] meta);
    bus.blk_start = 1'b1;
    bus.blk_meta  = meta;
    step();
    bus.blk_start = 1'b0;
    bus.blk_meta  = 8'h00;
  endtask

  // Feeds n bits of a block of length len; fb >= 0 holds fifo_full over that byte index.
  task automatic send_bits(input int n, input int len, input int mode, input bit gap, input int fb);
    int g = 0;
    int c = 0;
    logic valid, full_now, exp_wr, exp_done;
    logic [23:0] eb;
    eb = pattern_bytes(mode);
    n_writes = 0;
    n_done   = 0;
    pat_err  = 0;
    while (g < n) begin
      valid    = !(gap && (c % 3 == 2));
      full_now = (fb >= 0) && (g >= 8 * fb) && (g <= 8 * fb + 8);
      bus.enc_valid = valid;
      bus.dIn       = valid ? pattern(mode, g) : 3'b000;
      bus.fifo_full = full_now ? 3'b010 : 3'b000;
      exp_wr   = valid && (g % 8 == 7) && !full_now;
      exp_done = valid && (g == len - 1);
      step();
      if (bus.wrreq_out) n_writes++;
      if (bus.blk_done)  n_done++;
      if (bus.wrreq_out !== exp_wr || bus.blk_done !== exp_done) pat_err++;
      if (exp_wr && {bus.out_d2, bus.out_d1, bus.out_d0} !== eb) pat_err++;
      if (valid) g++;
      c++;
    end
    bus.enc_valid = 1'b0;
    bus.dIn       = 3'b000;
    bus.fifo_full = 3'b000;
  endtask

  initial begin
    reset         = 1'b1;
    bus.blk_start = 1'b0;
    bus.blk_meta  = 8'h00;
    bus.enc_valid = 1'b0;
    bus.dIn       = 3'b000;
    bus.fifo_full = 3'b000;
    step();
    step();
    checkOutput("rst_out_d0", 32'(bus.out_d0), 32'h0);
    checkOutput("rst_out_d1", 32'(bus.out_d1), 32'h0);
    checkOutput("rst_out_d2", 32'(bus.out_d2), 32'h0);
    checkOutput("rst_ctrl", {27'd0, bus.wrreq_out, bus.blk_done, bus.busy, bus.len_err, bus.overflow}, 32'h0);
    checkOutput("rst_bit_cnt", 32'(bus.bit_cnt), 32'h0);
    reset = 1'b0;
    step();

    $display("[TB] small block, dIn=101");
    applyStimulus(8'h00);
    checkOutput("a_busy", 32'(bus.busy), 32'h1);
    send_bits(1056, 1056, 0, 1'b0, -1);
    checkOutput("a_last_wr_done", {30'd0, bus.wrreq_out, bus.blk_done}, 32'h3);
    checkOutput("a_bit_cnt", 32'(bus.bit_cnt), 32'd1056);
    checkOutput("a_writes", 32'(n_writes), 32'd132);
    checkOutput("a_done", 32'(n_done), 32'd1);
    checkOutput("a_pattern", 32'(pat_err), 32'd0);
    checkOutput("a_len_err", 32'(bus.len_err), 32'h0);
    step();
    checkOutput("a_idle", {30'd0, bus.busy, bus.blk_done}, 32'h0);

    $display("[TB] large block with gaps");
    applyStimulus(8'h01);
    send_bits(6144, 6144, 1, 1'b1, -1);
    checkOutput("b_writes", 32'(n_writes), 32'd768);
    checkOutput("b_pattern", 32'(pat_err), 32'd0);
    checkOutput("b_out_d0", 32'(bus.out_d0), 32'hAA);
    checkOutput("b_bit_cnt", 32'(bus.bit_cnt), 32'd6144);
    step();

    $display("[TB] fifo full on byte 5");
    applyStimulus(8'hFE);
    send_bits(1056, 1056, 0, 1'b0, 4);
    checkOutput("c_writes", 32'(n_writes), 32'd131);
    checkOutput("c_done", 32'(n_done), 32'd1);
    checkOutput("c_pattern", 32'(pat_err), 32'd0);
    checkOutput("c_overflow", 32'(bus.overflow), 32'h1);
    step();

    $display("[TB] restart after 20 bits");
    applyStimulus(8'h00);
    send_bits(20, 1056, 2, 1'b0, -1);
    checkOutput("d_partial_writes", 32'(n_writes), 32'd2);
    bus.blk_start = 1'b1;
    bus.enc_valid = 1'b1;
    bus.dIn       = 3'b111;
    step();
    bus.blk_start = 1'b0;
    bus.enc_valid = 1'b0;
    bus.dIn       = 3'b000;
    checkOutput("d_len_err_pulse", 32'(bus.len_err), 32'h1);
    checkOutput("d_bit_cnt", 32'(bus.bit_cnt), 32'h0);
    checkOutput("d_no_write", 32'(bus.wrreq_out), 32'h0);
    step();
    checkOutput("d_len_err_clear", 32'(bus.len_err), 32'h0);
    send_bits(1056, 1056, 2, 1'b0, -1);
    checkOutput("d_writes", 32'(n_writes), 32'd132);
    checkOutput("d_pattern", 32'(pat_err), 32'd0);
    checkOutput("d_overflow_sticky", 32'(bus.overflow), 32'h1);
    step();

    $display("[TB] stray enc_valid in IDLE and LAST");
    bus.enc_valid = 1'b1;
    bus.dIn       = 3'b111;
    step();
    bus.enc_valid = 1'b0;
    checkOutput("e_idle_len_err", 32'(bus.len_err), 32'h1);
    checkOutput("e_idle_bit_cnt", 32'(bus.bit_cnt), 32'd1056);
    checkOutput("e_idle_no_write", 32'(bus.wrreq_out), 32'h0);
    applyStimulus(8'h00);
    send_bits(1056, 1056, 0, 1'b0, -1);
    checkOutput("e_cleared_by_start", 32'(bus.len_err), 32'h0);
    bus.enc_valid = 1'b1;
    bus.dIn       = 3'b111;
    step();
    bus.enc_valid = 1'b0;
    checkOutput("e_last_len_err", 32'(bus.len_err), 32'h1);
    checkOutput("e_last_bit_cnt", 32'(bus.bit_cnt), 32'd1056);
    checkOutput("e_last_idle", {30'd0, bus.busy, bus.wrreq_out}, 32'h0);

    $display("[TB] reset after 100 bits");
    applyStimulus(8'h00);
    send_bits(100, 1056, 2, 1'b0, -1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("f_bit_cnt", 32'(bus.bit_cnt), 32'h0);
    checkOutput("f_out_d", {8'd0, bus.out_d2, bus.out_d1, bus.out_d0}, 32'h0);
    checkOutput("f_ctrl", {27'd0, bus.wrreq_out, bus.blk_done, bus.busy, bus.len_err, bus.overflow}, 32'h0);
    step();
    applyStimulus(8'h00);
    send_bits(1056, 1056, 2, 1'b0, -1);
    checkOutput("f_writes", 32'(n_writes), 32'd132);
    checkOutput("f_done", 32'(n_done), 32'd1);
    checkOutput("f_pattern", 32'(pat_err), 32'd0);
    checkOutput("f_out_d1", 32'(bus.out_d1), 32'h55);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
